// File: rtl/cve2_ex_retire_buffer.sv
// cve2_ex_retire_buffer: EX result retire FIFO toward writeback plus intermediate/MAC value registers
module cve2_ex_retire_buffer #(
  parameter int unsigned WbDepth = 2,
  parameter bit          MacEn   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [31:0]      result_ex_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rf_we_i,
  input  logic             instr_mac_i,
  input  logic             acc_clr_i,
  input  logic             flush_i,
  input  logic [1:0]       imd_val_we_i,
  input  logic [1:0][33:0] imd_val_d_i,
  output logic [1:0][33:0] imd_val_q_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_addr_o,
  output logic [31:0]      wb_wdata_o,
  output logic             busy_o
);
  localparam int unsigned PW = (WbDepth > 1) ? $clog2(WbDepth) : 1;
  localparam int unsigned CW = $clog2(WbDepth + 1);
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [31:0]   data_q [WbDepth];
  logic [4:0]    rd_q   [WbDepth];
  logic          accept, push, pop, full, empty, mac_upd;
  logic [33:0]   imd0_d, imd1_d;
  assign full         = count == CW'(WbDepth);
  assign empty        = count == '0;
  assign ex_ready_o   = !full;
  assign accept       = ex_valid_i && ex_ready_o && !flush_i;
  assign push         = accept && rf_we_i && (rd_addr_i != 5'd0);
  assign pop          = wb_valid_o && wb_ready_i;
  assign wb_valid_o   = !empty;
  assign busy_o       = !empty;
  assign wb_wdata_o   = empty ? 32'd0 : data_q[rptr];
  assign wb_rd_addr_o = empty ? 5'd0 : rd_q[rptr];
  assign mac_upd      = MacEn && accept && instr_mac_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wptr] <= result_ex_i;
      rd_q[wptr]   <= rd_addr_i;
    end
  end
  // Accumulator priority: MAC retire, then EX write, then clear (clear keeps the top two bits)
  always_comb begin
    imd0_d = mac_upd          ? {2'b00, result_ex_i} :
             imd_val_we_i[0]  ? imd_val_d_i[0] :
             acc_clr_i        ? {imd_val_q_o[0][33:32], 32'd0} : imd_val_q_o[0];
    imd1_d = imd_val_we_i[1] ? imd_val_d_i[1] : imd_val_q_o[1];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) imd_val_q_o <= '0;
    else imd_val_q_o <= {imd1_d, imd0_d};
  end
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CW'(WbDepth));
  a_mac_imd_conflict: assert property (@(posedge clk_i) disable iff (!rst_ni) !(mac_upd && imd_val_we_i[0]));
  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wb_valid_o && !wb_ready_i && !flush_i) |=> (wb_valid_o && $stable(wb_wdata_o) && $stable(wb_rd_addr_o)));
endmodule
